fpu_fp32_mul_seq: RTL and testbench

//  Iterative IEEE-754 single-precision multiplier; the FPU execution stage feeding the APB FPU register bank.

---
 rtl/fpu_pkg.sv | 14 +
 rtl/fpu_mant_mul_iter.sv | 43 ++++
 rtl/fpu_fp32_mul_seq.sv | 169 ++++++++++++++++
 tb/tb_fpu_fp32_mul_seq.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the sequential fp32 multiplier.
package fpu_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, MULT, NORM, RND} state_t;

  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
  localparam int          FP_EXP_BIAS = 127;
  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;
endpackage

// File: rtl/fpu_mant_mul_iter.sv
// 24x24 shift-add mantissa multiplier, one partial product per cycle.
module fpu_mant_mul_iter #(
  parameter int MANT_STEPS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] ma,
  input  logic [23:0] mb,
  output logic [47:0] acc,
  output logic        done
);
  logic [47:0] ma_sh;
  logic [23:0] mb_sh;
  logic [4:0]  cnt;
  logic        run;

  // done marks the cycle whose clock edge adds the last partial product
  assign done = run && (cnt == 5'(MANT_STEPS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      ma_sh <= '0;
      mb_sh <= '0;
      acc   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
    end else if (load) begin
      ma_sh <= {24'b0, ma};
      mb_sh <= mb;
      acc   <= '0;
      cnt   <= '0;
      run   <= 1'b1;
    end else if (run) begin
      acc   <= acc + (mb_sh[0] ? ma_sh : 48'b0);
      ma_sh <= ma_sh << 1;
      mb_sh <= mb_sh >> 1;
      cnt   <= cnt + 5'd1;
      if (done)
        run <= 1'b0;
    end
  end
endmodule

// File: rtl/fpu_fp32_mul_seq.sv
// Iterative IEEE-754 single-precision multiplier (FTZ, round-to-nearest-even).
module fpu_fp32_mul_seq
  import fpu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MANT_STEPS = 24
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [DATA_W-1:0] OP1,
  input  logic [DATA_W-1:0] OP2,
  output logic              busy,
  output logic [DATA_W-1:0] Result_Fpu,
  output logic              Result_FPU_valid,
  output logic              zero_flag,
  output logic              INF_flag,
  output logic              NAN_flag
);
  state_t state, state_nxt;

  fp32_t              op_a_p0, op_b_p0;
  logic               sign_p1;
  logic signed [9:0]  exp_p1;
  logic [23:0]        mant_p2;
  logic               guard_p2, sticky_p2;

  logic [47:0]        acc;
  logic               mul_done, mul_load;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
  logic [24:0]        rnd_sum;
  logic signed [9:0]  exp_rnd;
  logic [22:0]        frac_rnd;

  function automatic logic [24:0] round_rne(input logic [23:0] mant,
                                            input logic guard,
                                            input logic sticky);
    return {1'b0, mant} + 25'(guard & (sticky | mant[0]));
  endfunction

  // Returns {inf, zero, result}; saturates the exponent range to Inf or flushed zero.
  function automatic logic [33:0] pack_result(input logic sign,
                                              input logic signed [9:0] e,
                                              input logic [22:0] frac);
    if (e >= 10'sd255)
      return {1'b1, 1'b0, sign, FP_EXP_MAX, 23'h0};
    else if (e <= 10'sd0)
      return {1'b0, 1'b1, sign, 31'h0};
    else
      return {1'b0, 1'b0, sign, e[7:0], frac};
  endfunction

  always_comb begin
    a_nan   = (op_a_p0.exp == FP_EXP_MAX) && (op_a_p0.frac != 23'h0);
    b_nan   = (op_b_p0.exp == FP_EXP_MAX) && (op_b_p0.frac != 23'h0);
    a_inf   = (op_a_p0.exp == FP_EXP_MAX) && (op_a_p0.frac == 23'h0);
    b_inf   = (op_b_p0.exp == FP_EXP_MAX) && (op_b_p0.frac == 23'h0);
    a_zero  = (op_a_p0.exp == 8'h00);
    b_zero  = (op_b_p0.exp == 8'h00);
    special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
  end

  always_comb begin
    rnd_sum  = round_rne(mant_p2, guard_p2, sticky_p2);
    exp_rnd  = exp_p1 + (rnd_sum[24] ? 10'sd1 : 10'sd0);
    frac_rnd = rnd_sum[24] ? 23'h0 : rnd_sum[22:0];
  end

  fpu_mant_mul_iter #(.MANT_STEPS(MANT_STEPS)) u_mant (
    .clk  (CLK),
    .rst  (RST),
    .load (mul_load),
    .ma   ({1'b1, op_a_p0.frac}),
    .mb   ({1'b1, op_b_p0.frac}),
    .acc  (acc),
    .done (mul_done)
  );

  always_ff @(posedge CLK) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   state_nxt = special ? IDLE : MULT;
      MULT:    if (mul_done) state_nxt = NORM;
      NORM:    state_nxt = RND;
      RND:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    mul_load = (state == CHECK) && !special;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_a_p0          <= '0;
      op_b_p0          <= '0;
      sign_p1          <= 1'b0;
      exp_p1           <= '0;
      mant_p2          <= '0;
      guard_p2         <= 1'b0;
      sticky_p2        <= 1'b0;
      Result_Fpu       <= '0;
      Result_FPU_valid <= 1'b0;
      zero_flag        <= 1'b0;
      INF_flag         <= 1'b0;
      NAN_flag         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_a_p0          <= OP1;
          op_b_p0          <= OP2;
          Result_FPU_valid <= 1'b0;
          zero_flag        <= 1'b0;
          INF_flag         <= 1'b0;
          NAN_flag         <= 1'b0;
        end
        // Classify: specials finish here, normal operands seed the exponent
        CHECK: begin
          sign_p1 <= op_a_p0.sign ^ op_b_p0.sign;
          exp_p1  <= $signed({2'b00, op_a_p0.exp}) + $signed({2'b00, op_b_p0.exp})
                     - $signed(10'(FP_EXP_BIAS));
          if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            Result_Fpu       <= FP_QNAN;
            NAN_flag         <= 1'b1;
            Result_FPU_valid <= 1'b1;
          end else if (a_inf || b_inf) begin
            Result_Fpu       <= {op_a_p0.sign ^ op_b_p0.sign, FP_EXP_MAX, 23'h0};
            INF_flag         <= 1'b1;
            Result_FPU_valid <= 1'b1;
          end else if (a_zero || b_zero) begin
            Result_Fpu       <= {op_a_p0.sign ^ op_b_p0.sign, 31'h0};
            zero_flag        <= 1'b1;
            Result_FPU_valid <= 1'b1;
          end
        end
        // Normalise: product of two [1,2) mantissas lies in [1,4)
        NORM: begin
          if (acc[47]) begin
            mant_p2   <= acc[47:24];
            guard_p2  <= acc[23];
            sticky_p2 <= |acc[22:0];
            exp_p1    <= exp_p1 + 10'sd1;
          end else begin
            mant_p2   <= acc[46:23];
            guard_p2  <= acc[22];
            sticky_p2 <= |acc[21:0];
          end
        end
        // Round and pack
        RND: begin
          {INF_flag, zero_flag, Result_Fpu} <= pack_result(sign_p1, exp_rnd, frac_rnd);
          Result_FPU_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_fp32_mul_seq.sv
// Directed bench for the sequential fp32 multiplier: vector table plus start/reset corner sequences.
module tb_fpu_fp32_mul_seq;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [31:0] OP1 = '0, OP2 = '0;
  logic        busy;
  logic [31:0] Result_Fpu;
  logic        Result_FPU_valid, zero_flag, INF_flag, NAN_flag;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fpu_fp32_mul_seq dut (
    .CLK              (CLK),
    .RST              (RST),
    .start            (start),
    .OP1              (OP1),
    .OP2              (OP2),
    .busy             (busy),
    .Result_Fpu       (Result_Fpu),
    .Result_FPU_valid (Result_FPU_valid),
    .zero_flag        (zero_flag),
    .INF_flag         (INF_flag),
    .NAN_flag         (NAN_flag)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flags;   // {nan, inf, zero}
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] flags_now();
    return {29'b0, NAN_flag, INF_flag, zero_flag};
  endfunction

  // Drives a one-cycle start; on return one rising edge (the accepting one) has passed.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    OP1 = a;
    OP2 = b;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    OP1 = $urandom;
    OP2 = $urandom;
  endtask

  task automatic wait_valid(inout int n);
    while (!Result_FPU_valid && n < 40) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic run_vec(input int i);
    int n;
    launch(vecs[i].a, vecs[i].b);
    n = 1;
    check($sformatf("v%0d_busy_on", i), {31'b0, busy}, 32'd1);
    wait_valid(n);
    check($sformatf("v%0d_latency", i), n, vecs[i].lat);
    check($sformatf("v%0d_result", i), Result_Fpu, vecs[i].res);
    check($sformatf("v%0d_flags", i), flags_now(), {29'b0, vecs[i].flags});
    check($sformatf("v%0d_busy_off", i), {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    vecs[0]  = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, 28};
    vecs[1]  = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 3'b000, 28};
    vecs[2]  = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 3'b000, 28};
    vecs[3]  = '{32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 3'b000, 28};
    vecs[4]  = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100, 2};
    vecs[5]  = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3'b010, 2};
    vecs[6]  = '{32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 3'b010, 28};
    vecs[7]  = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b001, 28};
    vecs[8]  = '{32'h8000_0001, 32'h3F80_0000, 32'h8000_0000, 3'b001, 2};
    vecs[9]  = '{32'hFF80_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b100, 2};
    vecs[10] = '{32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 3'b000, 28};
    vecs[11] = '{32'h3FFF_FFFF, 32'h3F80_0001, 32'h4000_0000, 3'b000, 28};
    vecs[12] = '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 3'b000, 28};

    repeat (3) @(negedge CLK);
    check("rst_result", Result_Fpu, 32'h0);
    check("rst_valid", {31'b0, Result_FPU_valid}, 32'd0);
    check("rst_flags", flags_now(), 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    RST = 1'b0;

    for (int i = 0; i < 13; i++)
      run_vec(i);

    // Start while busy is ignored; the accepted start clears the previous NaN flag
    launch(32'h7F80_0000, 32'h0000_0000);
    n = 1;
    wait_valid(n);
    check("pre_nan_flag", {31'b0, NAN_flag}, 32'd1);
    launch(32'h4000_0000, 32'h4040_0000);
    n = 1;
    check("clr_valid", {31'b0, Result_FPU_valid}, 32'd0);
    check("clr_flags", flags_now(), 32'd0);
    while (n < 10) begin
      @(negedge CLK);
      n++;
    end
    OP1 = 32'h3FC0_0000;
    OP2 = 32'h3FC0_0000;
    start = 1'b1;
    @(negedge CLK);
    n++;
    start = 1'b0;
    wait_valid(n);
    check("busy_start_latency", n, 28);
    check("busy_start_result", Result_Fpu, 32'h40C0_0000);
    check("busy_start_flags", flags_now(), 32'd0);
    repeat (3) @(negedge CLK);
    check("hold_result", Result_Fpu, 32'h40C0_0000);
    check("hold_valid", {31'b0, Result_FPU_valid}, 32'd1);
    launch(32'h3FC0_0000, 32'h3FC0_0000);
    n = 1;
    check("next_clr_valid", {31'b0, Result_FPU_valid}, 32'd0);
    wait_valid(n);
    check("next_result", Result_Fpu, 32'h4010_0000);

    // Reset mid-operation aborts everything
    launch(32'h4000_0000, 32'h4040_0000);
    n = 1;
    while (n < 15) begin
      @(negedge CLK);
      n++;
    end
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_result", Result_Fpu, 32'h0);
    check("midrst_valid", {31'b0, Result_FPU_valid}, 32'd0);
    check("midrst_flags", flags_now(), 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    RST = 1'b0;
    repeat (30) @(negedge CLK);
    check("midrst_no_partial", {31'b0, Result_FPU_valid}, 32'd0);
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
